// File: rtl/dec_scan_pkg.sv
// Shared types and constants for the decoder scan controller.
package dec_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } scan_state_t;

    localparam int   SEL_W        = 3;
    localparam int   NUM_IDX      = 8;
    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/dec_scan_ctrl_dwell_timer.sv
// Per-index dwell timer: loads the dwell count and flags its final cycle.
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Load on entry to ACTIVE, then count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    // A count of 1 marks the last active cycle of the current index.
    assign expire = (cnt == W'(1));

endmodule

// File: rtl/dec_scan_ctrl.sv
// Scan controller that walks a 3-to-8 decoder through all indices with a
// programmable dwell and a one-cycle blanking gap between indices.
import dec_scan_pkg::*;

module dec_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    scan_state_t        state, state_d;
    logic               mode_q;
    logic [DWELL_W-1:0] dwell_q, dwell_eff, load_val;
    logic               start_ok, last_idx, expire, load;
    logic [SEL_W-1:0]   sel_d;
    logic               en_d, busy_d, done_d, wrap_d;

    // A dwell of zero would never expire, so it is promoted to one.
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign start_ok  = (state == IDLE) && start && !stop;
    assign last_idx  = (sel == SEL_W'(NUM_IDX - 1));
    assign load      = (state_d == ACTIVE) && (state != ACTIVE);
    // On the accepting start the latched copy is not yet valid, so bypass it.
    assign load_val  = (state == IDLE) ? dwell_eff : dwell_q;

    dwell_timer #(.W(DWELL_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    // Capture scan parameters only when a scan is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q <= '0;
            mode_q  <= MODE_CONT;
        end else if (start_ok) begin
            dwell_q <= dwell_eff;
            mode_q  <= mode;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Next-state logic; stop aborts from any busy state.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start_ok) state_d = ACTIVE;
            ACTIVE:  if (stop) state_d = IDLE;
                     else if (expire) state_d = BLANK;
            BLANK:   if (stop || (last_idx && mode_q == MODE_ONESHOT)) state_d = IDLE;
                     else state_d = ACTIVE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the output registers, decoded from the transition.
    always_comb begin
        sel_d  = sel;
        en_d   = (state_d == ACTIVE);
        busy_d = (state_d != IDLE);
        done_d = 1'b0;
        wrap_d = 1'b0;
        if (state_d == IDLE)
            sel_d = '0;
        else if (state == BLANK && state_d == ACTIVE)
            sel_d = last_idx ? '0 : sel + SEL_W'(1);
        if (state == BLANK && !stop && last_idx) begin
            done_d = (mode_q == MODE_ONESHOT);
            wrap_d = (mode_q == MODE_CONT);
        end
    end

    // Output registers so no input reaches a port combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel  <= '0;
            en   <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            wrap <= 1'b0;
        end else begin
            sel  <= sel_d;
            en   <= en_d;
            busy <= busy_d;
            done <= done_d;
            wrap <= wrap_d;
        end
    end

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Self-checking bench for dec_scan_ctrl against a cycle-formula reference.
module tb_dec_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [2:0] sel;
    logic       en, busy, done, wrap;

    int n_pass = 0;
    int n_total = 0;

    dec_scan_ctrl #(.DWELL_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .dwell (dwell),
        .sel   (sel),
        .en    (en),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    // Expected {sel,en,busy,done,wrap} in cycle t after start sampled in
    // cycle 0; each index occupies D active cycles plus one blank cycle.
    function automatic logic [6:0] model(int t, bit m, int d, int abort);
        int dd, per, idx, ph;
        logic [2:0] s;
        logic e, b, dn, w;
        s = 3'd0; e = 1'b0; b = 1'b0; dn = 1'b0; w = 1'b0;
        dd  = (d == 0) ? 1 : d;
        per = dd + 1;
        if (t >= 1 && !(abort >= 0 && t > abort)) begin
            idx = (t - 1) / per;
            ph  = (t - 1) % per;
            if (m) begin
                if (idx < 8) begin
                    s = 3'(idx); e = (ph < dd); b = 1'b1;
                end else if (t == 8 * per + 1) begin
                    dn = 1'b1;
                end
            end else begin
                s = 3'(idx % 8); e = (ph < dd); b = 1'b1;
                w = (ph == 0 && idx > 0 && (idx % 8) == 0);
            end
        end
        return {s, e, b, dn, w};
    endfunction

    // Return to IDLE between scenarios.
    task automatic cleanup();
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b1; rst = 1'b0;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    // noise: 0 quiet, 1 random start/mode/dwell while busy, 2 start pulsing with dwell=5.
    task automatic run_scan(input string name, input bit m, input int d, input int abort,
                            input bit abort_rst, input int noise, input int len);
        logic [6:0] exp_v, got;
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b0; rst = 1'b0; mode = m; dwell = 8'(d);
        @(negedge clk);
        got = {sel, en, busy, done, wrap};
        exp_v = model(0, m, d, abort);
        n_total++;
        if (got !== exp_v) $display("FAIL %s t=0 got=%h exp=%h", name, got, exp_v);
        else n_pass++;
        for (int t = 1; t <= len; t++) begin
            @(posedge clk); #1;
            exp_v = model(t, m, d, abort);
            start = 1'b0;
            if (noise == 1) begin
                start = exp_v[2] ? 1'($urandom) : 1'b0;
                mode  = 1'($urandom);
                dwell = 8'($urandom);
            end else if (noise == 2) begin
                start = exp_v[2] ? 1'(t % 2) : 1'b0;
                dwell = 8'd5;
            end
            stop = (t == abort) && !abort_rst;
            rst  = (t == abort) && abort_rst;
            @(negedge clk);
            got = {sel, en, busy, done, wrap};
            n_total++;
            if (got !== exp_v)
                $display("FAIL %s t=%0d got=%h exp=%h (sel,en,busy,done,wrap)", name, t, got, exp_v);
            else n_pass++;
        end
        cleanup();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if ({sel, en, busy, done, wrap} !== 7'd0)
            $display("FAIL reset_state got=%h exp=00", {sel, en, busy, done, wrap});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_idle_start_stop();
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b1; dwell = 8'd2;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({sel, en, busy, done, wrap} !== 7'd0)
                $display("FAIL start_stop_idle cyc=%0d got=%h exp=00", i, {sel, en, busy, done, wrap});
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_oneshot();
        run_scan("oneshot_d2", 1'b1, 2, -1, 1'b0, 0, 28);
        run_scan("oneshot_d0", 1'b1, 0, -1, 1'b0, 0, 20);
    endtask

    task automatic test_continuous();
        run_scan("cont_d1", 1'b0, 1, -1, 1'b0, 0, 36);
    endtask

    task automatic test_stop();
        // sel=3 is active in cycles 10..11 with D=2; stop sampled in cycle 10.
        run_scan("stop_sel3", 1'b1, 2, 10, 1'b0, 0, 14);
        run_scan("stop_cont_blank", 1'b0, 1, 16, 1'b0, 0, 20);
    endtask

    task automatic test_busy_ignore();
        run_scan("restart_dwell5", 1'b1, 2, -1, 1'b0, 2, 28);
    endtask

    task automatic test_midscan_reset();
        // sel=6 is active in cycles 19..20 with D=2.
        run_scan("rst_sel6", 1'b1, 2, 19, 1'b1, 0, 22);
        run_scan("after_rst", 1'b1, 2, -1, 1'b0, 0, 4);
    endtask

    task automatic test_max_dwell();
        run_scan("max_dwell", 1'b1, 255, -1, 1'b0, 0, 8 * 256 + 3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            bit m;
            int d, per, ab, len;
            m   = 1'($urandom);
            d   = int'($urandom_range(0, 4));
            per = ((d == 0) ? 1 : d) + 1;
            len = m ? 8 * per + 3 : 16 * per + 3;
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8 * per)) : -1;
            run_scan($sformatf("random_%0d", i), m, d, ab, 1'($urandom), 1, len);
        end
    endtask

    initial begin
        test_reset();
        test_idle_start_stop();
        test_oneshot();
        test_continuous();
        test_stop();
        test_busy_ignore();
        test_midscan_reset();
        test_max_dwell();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dec_scan_ctrl.md
DEC_SCAN_CTRL -- requirements
Module: dec_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 8: width of the dwell-time input.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a scan; sampled only in IDLE.
REQ-005 SHALL have port stop, input, 1 bit: abort request; sampled in every state.
REQ-006 SHALL have port mode, input, 1 bit: 0 = continuous scan, 1 = one-shot scan; latched on an accepted start.
REQ-007 SHALL have port dwell, input, DWELL_W bits: number of active cycles per index; latched on an accepted start.
REQ-008 SHALL have port sel, output, 3 bits: index to drive into dec3to8 data_in.
REQ-009 SHALL have port en, output, 1 bit: enable to drive into dec3to8 en.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a one-shot scan completes.
REQ-012 SHALL have port wrap, output, 1 bit: one-cycle pulse when a continuous scan returns sel to 0.
REQ-013 SHALL register all outputs; no input may reach an output combinationally.

Function
REQ-014 SHALL implement the states IDLE, ACTIVE and BLANK.
REQ-015 SHALL, in IDLE, hold sel = 0 and en = 0, and leave IDLE only on start = 1 with stop = 0.
REQ-016 SHALL, when start is sampled in cycle 0, drive ACTIVE with sel = 0 and en = 1 from cycle 1.
REQ-017 SHALL treat a latched dwell value of 0 as 1; the effective dwell is D.
REQ-018 SHALL keep ACTIVE for exactly D cycles with en = 1 and sel constant, then enter BLANK.
REQ-019 SHALL keep BLANK for exactly 1 cycle with en = 0 and sel unchanged (anti-ghosting gap).
REQ-020 SHALL, on leaving BLANK with sel < 7, increment sel and return to ACTIVE.
REQ-021 SHALL, on leaving BLANK with sel = 7 in continuous mode, set sel = 0, return to ACTIVE, and assert wrap in that same cycle.
REQ-022 SHALL, on leaving BLANK with sel = 7 in one-shot mode, go to IDLE with sel = 0, busy = 0, and done = 1 for one cycle.
REQ-023 SHALL produce this one-shot timing: index i is active in cycles i(D+1)+1 through i(D+1)+D, and done is high in cycle 8(D+1)+1.
REQ-024 SHALL, on stop sampled in ACTIVE or BLANK, enter IDLE in the next cycle with sel = 0 and en = 0, and SHALL NOT assert done or wrap.
REQ-025 SHALL ignore start while busy; dwell and mode changes while busy SHALL have no effect.
REQ-026 SHALL stay in IDLE when start and stop are high together in IDLE (stop wins).
REQ-027 SHALL make the dwell counter DWELL_W bits wide with no overflow; the maximum dwell is 2^DWELL_W-1.

Reset
REQ-028 SHALL, on rst = 1 at a clock edge, force IDLE, sel = 0, en = 0, busy = 0, done = 0, wrap = 0, and clear the dwell counter and latched mode/dwell.
REQ-029 SHALL give rst priority over start and stop, and a mid-scan reset SHALL produce no done or wrap pulse.

Structure
REQ-030 SHALL place in package dec_scan_pkg: the state enumeration (IDLE/ACTIVE/BLANK), SEL_W = 3, NUM_IDX = 8, and the encoding constants MODE_CONT = 0 and MODE_ONESHOT = 1.
REQ-031 SHALL implement the per-index cycle count in one sub-module, dwell_timer (load, count-down, expire flag), instantiated once.

Verification
REQ-032 SHALL verify one-shot, dwell = 2, start in cycle 0 -> sel 0..7 each with en high for 2 cycles and a 1-cycle en-low gap, done = 1 in cycle 25 only, and busy = 0 from cycle 25.
REQ-033 SHALL verify one-shot, dwell = 0 -> behaves as D = 1, each index period is 2 cycles, and done = 1 in cycle 17.
REQ-034 SHALL verify continuous, dwell = 1 -> wrap = 1 in cycle 17 with sel = 0 and en = 1, a second wrap in cycle 33, and no done ever.
REQ-035 SHALL verify stop while sel = 3 in ACTIVE -> next cycle sel = 0, en = 0, busy = 0, with no done and no wrap.
REQ-036 SHALL verify start re-pulsed and dwell changed to 5 mid-scan with dwell = 2 latched -> timing is unchanged and done still occurs in cycle 25.
REQ-037 SHALL verify rst = 1 at sel = 6 -> next cycle all outputs 0 in IDLE, and a following start gives sel = 0, en = 1 one cycle later.
